// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequential multi-bit shift unit for the ALU logic group.
// A working register is loaded on an accepted start and then passed
// through a single-position shift stage once per clock until the
// requested amount is exhausted. Supports SLL, SRL, SRA and ROR.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request pulse, accepted only while busy=0 (IDLE or DONE)
//   op    - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   amt   - shift amount 0..WIDTH-1
//   din   - operand
//   busy  - high while shifting
//   done  - one-cycle completion pulse
//   dout  - result (working register), valid from done until next start
//   cout  - last bit shifted/rotated out, 0 when amt=0
//   zero  - dout == 0, registered alongside dout
module alu_shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic [WIDTH:0]   step_s;

  // Single-position shift stage: returns {bit_out, shifted_word}.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] f_op,
                                                input logic [WIDTH-1:0] w);
    logic [WIDTH:0] r;
    case (f_op)
      OP_SLL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {w[0], 1'b0, w[WIDTH-1:1]};
      OP_SRA:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROR:  r = {w[0], w[0], w[WIDTH-1:1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  // A start is honoured in IDLE and DONE, never while shifting.
  assign accept_s = start && (state_q != ST_SHIFT);
  assign step_s   = shift_step(op_q, work_q);

  // State register and datapath flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= {SHW{1'b0}};
      op_q    <= 2'b00;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SHIFT;
        else       state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q == {SHW{1'b0}}) state_d = ST_DONE;
        else                      state_d = ST_SHIFT;
      end
      ST_DONE: begin
        if (start) state_d = ST_SHIFT;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: busy/done are registered from the next state so they
  // line up with the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE:  begin busy_d = 1'b0; done_d = 1'b0; end
      ST_SHIFT: begin busy_d = 1'b1; done_d = 1'b0; end
      ST_DONE:  begin busy_d = 1'b0; done_d = 1'b1; end
      default:  begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // Datapath: load on accept, one shift per SHIFT cycle while cnt != 0.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    cout_d = cout_q;
    if (accept_s) begin
      work_d = din;
      cnt_d  = amt;
      op_d   = op;
      cout_d = 1'b0;
    end else if ((state_q == ST_SHIFT) && (cnt_q != {SHW{1'b0}})) begin
      work_d = step_s[WIDTH-1:0];
      cout_d = step_s[WIDTH];
      cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
    end else begin
      work_d = work_q;
    end
    zero_d = (work_d == {WIDTH{1'b0}});
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = work_q;
  assign cout = cout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed test-plan steps followed by
// randomized operations, all compared against an arithmetic reference model.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amt;
  logic [31:0] din;
  logic        busy, done, cout, zero;
  logic [31:0] dout;

  int checks   = 0;
  int failures = 0;

  alu_shift_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .din(din),
    .busy(busy), .done(done), .dout(dout), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: {cout, result} from plain shift/rotate arithmetic.
  function automatic logic [32:0] model(input logic [1:0] m_op,
                                        input logic [31:0] m_din,
                                        input int m_amt);
    logic [31:0] res;
    logic        co;
    case (m_op)
      2'b00:   res = m_din << m_amt;
      2'b01:   res = m_din >> m_amt;
      2'b10:   res = $signed(m_din) >>> m_amt;
      default: res = (m_amt == 0) ? m_din : ((m_din >> m_amt) | (m_din << (32 - m_amt)));
    endcase
    if (m_amt == 0)        co = 1'b0;
    else if (m_op == 2'b00) co = m_din[32 - m_amt];
    else                    co = m_din[m_amt - 1];
    return {co, res};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request and take it through the accepting edge (edge 0).
  task automatic start_op(input logic [1:0] s_op, input logic [31:0] s_din,
                          input logic [4:0] s_amt);
    op = s_op; din = s_din; amt = s_amt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", {63'd0, busy}, 64'd1);
    check("accept_done", {63'd0, done}, 64'd0);
    check("accept_cout", {63'd0, cout}, 64'd0);
  endtask

  // Wait (bounded) for done and verify latency, busy length and results.
  task automatic wait_done(input logic [1:0] w_op, input logic [31:0] w_din,
                           input logic [4:0] w_amt, input bit hold);
    logic [32:0] exp;
    int edges    = 0;
    int busy_cnt = 1;
    bit seen     = 1'b0;
    exp = model(w_op, w_din, int'(w_amt));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (hold) begin
        start = 1'b1;
        din   = $urandom;
        amt   = 5'($urandom);
        op    = 2'($urandom);
      end
    end
    start = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    check("latency", 64'(edges), 64'(int'(w_amt) + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(int'(w_amt) + 1));
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("dout", {32'd0, dout}, {32'd0, exp[31:0]});
    check("cout", {63'd0, cout}, {63'd0, exp[32]});
    check("zero", {63'd0, zero}, {63'd0, (exp[31:0] == 32'd0)});
  endtask

  // One idle cycle after done: pulse gone, result held.
  task automatic check_idle(input logic [1:0] c_op, input logic [31:0] c_din,
                            input logic [4:0] c_amt);
    logic [32:0] exp;
    exp = model(c_op, c_din, int'(c_amt));
    @(posedge clk); #1;
    check("done_pulse_end", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("hold_dout", {32'd0, dout}, {32'd0, exp[31:0]});
    check("hold_cout", {63'd0, cout}, {63'd0, exp[32]});
  endtask

  task automatic run(input logic [1:0] r_op, input logic [31:0] r_din,
                     input logic [4:0] r_amt);
    start_op(r_op, r_din, r_amt);
    wait_done(r_op, r_din, r_amt, 1'b0);
    check_idle(r_op, r_din, r_amt);
  endtask

  initial begin
    logic [1:0]  p_op, q_op;
    logic [31:0] p_din, q_din;
    logic [4:0]  p_amt, q_amt;
    bit          seen_done;

    rst = 1'b1; start = 1'b0; op = 2'b00; amt = 5'd0; din = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dout", {32'd0, dout}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    rst = 1'b0;

    // Directed test-plan operations.
    run(2'b00, 32'h0000_0001, 5'd4);
    run(2'b10, 32'h8000_0000, 5'd31);
    run(2'b01, 32'h8000_0003, 5'd1);
    run(2'b11, 32'h0000_0001, 5'd1);
    for (int k = 0; k < 4; k++) run(2'(k), 32'h1234_5678, 5'd0);
    run(2'b00, 32'h0000_0001, 5'd31);
    run(2'b00, 32'h8000_0000, 5'd1);

    // start held during SHIFT with changing operands is ignored.
    start_op(2'b01, 32'hF0F0_F0F0, 5'd9);
    wait_done(2'b01, 32'hF0F0_F0F0, 5'd9, 1'b1);
    check_idle(2'b01, 32'hF0F0_F0F0, 5'd9);

    // Back-to-back: start accepted in the DONE cycle.
    start_op(2'b11, 32'hA5A5_0001, 5'd3);
    wait_done(2'b11, 32'hA5A5_0001, 5'd3, 1'b0);
    start_op(2'b10, 32'h8765_4321, 5'd7);
    wait_done(2'b10, 32'h8765_4321, 5'd7, 1'b0);
    check_idle(2'b10, 32'h8765_4321, 5'd7);

    // Reset at edge 7 of an SLL by 20: discarded, no done afterwards.
    start_op(2'b00, 32'hDEAD_BEEF, 5'd20);
    repeat (6) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_dout", {32'd0, dout}, 64'd0);
    check("midrst_zero", {63'd0, zero}, 64'd1);
    check("midrst_cout", {63'd0, cout}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("midrst_no_done", {63'd0, seen_done}, 64'd0);
    run(2'b01, 32'hCAFE_F00D, 5'd12);

    // Randomized operations, some chained back-to-back.
    for (int n = 0; n < 40; n++) begin
      p_op = 2'($urandom); p_din = $urandom; p_amt = 5'($urandom);
      if (($urandom % 4) == 0) p_din = {31'd0, 1'b1} << ($urandom % 32);
      start_op(p_op, p_din, p_amt);
      wait_done(p_op, p_din, p_amt, ($urandom % 3) == 0);
      if (($urandom % 2) == 0) begin
        q_op = 2'($urandom); q_din = $urandom; q_amt = 5'($urandom);
        start_op(q_op, q_din, q_amt);
        wait_done(q_op, q_din, q_amt, 1'b0);
        check_idle(q_op, q_din, q_amt);
      end else begin
        check_idle(p_op, p_din, p_amt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
